// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU arbiter: datapath width,
// ALU opcodes and arbiter FSM states.
package alu_pkg;

  localparam int unsigned ALU_W = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SHL = 3'b010,
    OP_SHR = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_EQ  = 3'b111
  } alu_op_e;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu_rr_arbiter_alu.sv
// Simple_ALU: purely combinational 8-bit ALU shared by the arbiter's requesters.
module Simple_ALU
  import alu_pkg::*;
(
  input  logic [2:0]       op_i,
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  output logic [ALU_W-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (alu_op_e'(op_i))
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_SHL:  result_o = a_i << b_i[2:0];
      OP_SHR:  result_o = a_i >> b_i[2:0];
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_EQ:   result_o = {{(ALU_W-1){1'b0}}, (a_i == b_i)};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin arbiter with bounded lock in front of one shared
// Simple_ALU; the result is registered and returned tagged with the requester id.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned PRIO_INIT = 0,
  parameter int unsigned LOCK_MAX  = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic             req0_lock_i,
  input  logic [2:0]       req0_op_i,
  input  logic [ALU_W-1:0] req0_a_i,
  input  logic [ALU_W-1:0] req0_b_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic             req1_lock_i,
  input  logic [2:0]       req1_op_i,
  input  logic [ALU_W-1:0] req1_a_i,
  input  logic [ALU_W-1:0] req1_b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [ALU_W-1:0] rsp_data_o,
  output logic             rsp_id_o,
  output logic             rsp_zero_o,
  output logic [CNT_W-1:0] op_cnt_o
);

  localparam int unsigned LCW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX + 1) : 1;
  localparam logic PTR_RST = (PRIO_INIT != 0);

  arb_state_e       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ALU_W-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;

  logic             can_accept;
  logic             gnt_valid;
  logic             gnt_id;
  logic             accept;
  logic             gnt_lock;
  logic             owner_valid;
  logic [2:0]       alu_op;
  logic [ALU_W-1:0] alu_a, alu_b, alu_res;

  // Grant selection and operand mux feeding the shared ALU.
  always_comb begin
    can_accept  = !rsp_valid_q || rsp_ready_i;
    owner_valid = owner_q ? req1_valid_i : req0_valid_i;
    gnt_valid   = 1'b0;
    gnt_id      = 1'b0;
    if (state_q == ST_LOCKED) begin
      gnt_valid = owner_valid;
      gnt_id    = owner_q;
    end else if (req0_valid_i && req1_valid_i) begin
      gnt_valid = 1'b1;
      gnt_id    = ptr_q;
    end else if (req0_valid_i || req1_valid_i) begin
      gnt_valid = 1'b1;
      gnt_id    = req1_valid_i;
    end
    accept       = can_accept && gnt_valid;
    req0_ready_o = accept && !gnt_id;
    req1_ready_o = accept && gnt_id;
    gnt_lock     = gnt_id ? req1_lock_i : req0_lock_i;
    alu_op       = gnt_id ? req1_op_i : req0_op_i;
    alu_a        = gnt_id ? req1_a_i  : req0_a_i;
    alu_b        = gnt_id ? req1_b_i  : req0_b_i;
  end

  Simple_ALU u_alu (
    .op_i     (alu_op),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_res)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    lock_cnt_d  = lock_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_zero_d  = rsp_zero_q;
    op_cnt_d    = op_cnt_q;

    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = alu_res;
      rsp_id_d    = gnt_id;
      rsp_zero_d  = (alu_res == '0);
      op_cnt_d    = op_cnt_q + 1'b1;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      ST_ARB: begin
        if (accept) begin
          if (gnt_lock && (LOCK_MAX > 1)) begin
            state_d    = ST_LOCKED;
            owner_d    = gnt_id;
            lock_cnt_d = LCW'(1);
          end else begin
            ptr_d = !gnt_id;
          end
        end
      end
      ST_LOCKED: begin
        // An absent owner releases the lock; a stalled response does not.
        if ((accept && (!gnt_lock || (LCW'(lock_cnt_q + 1'b1) == LCW'(LOCK_MAX))))
            || !owner_valid) begin
          state_d    = ST_ARB;
          ptr_d      = !owner_q;
          lock_cnt_d = '0;
        end else if (accept) begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_ARB;
      ptr_q       <= PTR_RST;
      owner_q     <= 1'b0;
      lock_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
      rsp_zero_q  <= 1'b0;
      op_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      lock_cnt_q  <= lock_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_zero_q  <= rsp_zero_d;
      op_cnt_q    <= op_cnt_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_zero_o  = rsp_zero_q;
  assign op_cnt_o    = op_cnt_q;

endmodule
